// File: rtl/fft_pkg.sv
// Shared helpers for the mixed-radix FFT pipeline: width derivation,
// counter sizing and the saturate/scale rule applied after butterfly add/sub.
package fft_pkg;

  localparam int MAX_W = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int data_width(input int integer_size, input int fract_size);
    return integer_size + fract_size;
  endfunction

  // Saturate a wide signed value to w bits, or halve it (floor) when scale is set.
  function automatic logic signed [MAX_W-1:0] sat_shift(input logic signed [MAX_W-1:0] v,
                                                        input int w,
                                                        input logic scale);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (scale) return v >>> 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sdf_r2_butterfly_stage_if.sv
// Sample stream into and out of the SDF butterfly stage; slave is the stage side.
interface sdf_r2_butterfly_stage_if #(
  parameter int DATA_WIDTH = 18,
  parameter int CNT_WIDTH  = 6
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_r;
  logic signed [DATA_WIDTH-1:0] in_i;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_r;
  logic signed [DATA_WIDTH-1:0] out_i;
  logic        [CNT_WIDTH-1:0]  out_cnt;

  modport master (
    output in_valid, in_r, in_i,
    input  out_valid, out_r, out_i, out_cnt
  );

  modport slave (
    input  in_valid, in_r, in_i,
    output out_valid, out_r, out_i, out_cnt
  );
endinterface

// File: rtl/sdf_feedback_fifo.sv
// Circular feedback buffer of DELAY complex words; the head read on an enabled
// cycle is the word written DELAY enabled cycles earlier, then overwritten.
module sdf_feedback_fifo
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int DELAY      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] wr_r,
  input  logic signed [DATA_WIDTH-1:0] wr_i,
  output logic signed [DATA_WIDTH-1:0] rd_r,
  output logic signed [DATA_WIDTH-1:0] rd_i
);

  localparam int PTR_W = clog2(DELAY);

  logic signed [DATA_WIDTH-1:0] mem_r [DELAY];
  logic signed [DATA_WIDTH-1:0] mem_i [DELAY];
  logic        [PTR_W-1:0]      ptr;

  assign rd_r = mem_r[ptr];
  assign rd_i = mem_i[ptr];

  // DELAY is a power of two, so the pointer wraps on its own.
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (en) ptr <= ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[ptr] <= wr_r;
      mem_i[ptr] <= wr_i;
    end
  end

endmodule

// File: rtl/sdf_r2_butterfly_stage.sv
// Radix-2 SDF butterfly stage: pairs samples DELAY apart through the feedback
// buffer, emits sums in the second half-frame and differences in the next first half.
module sdf_r2_butterfly_stage
  import fft_pkg::*;
#(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int DELAY        = 32,
  parameter int SCALE        = 0
) (
  input logic                    clk,
  input logic                    rst,
  sdf_r2_butterfly_stage_if.slave bus
);

  localparam int DATA_WIDTH = data_width(INTEGER_SIZE, FRACT_SIZE);
  localparam int CNT_W      = clog2(2 * DELAY);

  function automatic logic signed [DATA_WIDTH-1:0] fit(input logic signed [DATA_WIDTH:0] v);
    logic signed [MAX_W-1:0] wide;
    wide = {{(MAX_W-DATA_WIDTH-1){v[DATA_WIDTH]}}, v};
    return DATA_WIDTH'(sat_shift(wide, DATA_WIDTH, SCALE != 0));
  endfunction

  logic [CNT_W-1:0]             in_cnt;
  logic                         primed;
  logic                         bfly;
  logic signed [DATA_WIDTH-1:0] head_r, head_i;
  logic signed [DATA_WIDTH-1:0] wr_r, wr_i;
  logic signed [DATA_WIDTH-1:0] res_r, res_i;
  logic signed [DATA_WIDTH:0]   sum_r, sum_i, dif_r, dif_i;

  logic                         vld_p1;
  logic signed [DATA_WIDTH-1:0] r_p1, i_p1;
  logic [CNT_W-1:0]             cnt_p1;

  // Upper half of the frame (in_cnt >= DELAY) is the butterfly phase.
  assign bfly = in_cnt[CNT_W-1];

  sdf_feedback_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DELAY      (DELAY)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.in_valid),
    .wr_r (wr_r),
    .wr_i (wr_i),
    .rd_r (head_r),
    .rd_i (head_i)
  );

  // Stage p0: butterfly on buffer head and incoming sample.
  assign sum_r = {head_r[DATA_WIDTH-1], head_r} + {bus.in_r[DATA_WIDTH-1], bus.in_r};
  assign sum_i = {head_i[DATA_WIDTH-1], head_i} + {bus.in_i[DATA_WIDTH-1], bus.in_i};
  assign dif_r = {head_r[DATA_WIDTH-1], head_r} - {bus.in_r[DATA_WIDTH-1], bus.in_r};
  assign dif_i = {head_i[DATA_WIDTH-1], head_i} - {bus.in_i[DATA_WIDTH-1], bus.in_i};

  always_comb begin
    wr_r  = bus.in_r;
    wr_i  = bus.in_i;
    res_r = head_r;
    res_i = head_i;
    if (bfly) begin
      wr_r  = fit(dif_r);
      wr_i  = fit(dif_i);
      res_r = fit(sum_r);
      res_i = fit(sum_i);
    end
  end

  // Stage p1: registered output; data holds across input gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
      primed <= 1'b0;
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
      r_p1   <= '0;
      i_p1   <= '0;
    end else begin
      vld_p1 <= bus.in_valid & (primed | (in_cnt == CNT_W'(DELAY)));
      if (bus.in_valid) begin
        in_cnt <= in_cnt + 1'b1;
        if (in_cnt == CNT_W'(DELAY - 1)) primed <= 1'b1;
        cnt_p1 <= in_cnt - CNT_W'(DELAY);
        r_p1   <= res_r;
        i_p1   <= res_i;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_r     = r_p1;
  assign bus.out_i     = i_p1;
  assign bus.out_cnt   = cnt_p1;

endmodule
